// File: rtl/hv_sequencer.sv
// High-voltage supply sequencer: ramps, monitors and discharges an HV rail,
// latching comparator faults until the host acknowledges them.
module hv_sequencer #(
    parameter int RAMP_CYC  = 50000,
    parameter int DISCH_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_on,
    input  logic       cmd_pol,
    input  logic       fault_clr,
    input  logic       vn_l,
    input  logic       vn_h,
    output logic       vn_on,
    output logic       vn_pol,
    output logic       hv_ready,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    localparam int MAX_CYC = (RAMP_CYC > DISCH_CYC) ? RAMP_CYC : DISCH_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] RAMP_LAST  = CW'(RAMP_CYC - 1);
    localparam logic [CW-1:0] DISCH_LAST = CW'(DISCH_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RAMP  = 3'd1,
        S_ON    = 3'd2,
        S_DISCH = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            vn_on_q, vn_on_d;
    logic            vn_pol_q, vn_pol_d;
    logic            hv_ready_q, hv_ready_d;
    logic            fault_q, fault_d;
    logic [1:0]      fault_code_q, fault_code_d;

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        vn_pol_d     = vn_pol_q;

        unique case (state_q)
            S_OFF: begin
                // Polarity tracks the host only here; entry waits for it to settle.
                vn_pol_d = cmd_pol;
                if (cmd_on && (vn_pol_q == cmd_pol)) begin
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (vn_h) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd1;
                end else if ((cnt_q == RAMP_LAST) && vn_l) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd3;
                end else if (!cmd_on) begin
                    state_d = S_DISCH;
                end else if (!vn_l) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (vn_h) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd1;
                end else if (vn_l) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd2;
                end else if (!cmd_on || (cmd_pol != vn_pol_q)) begin
                    state_d = S_DISCH;
                end
            end
            S_DISCH: begin
                if (cnt_q == DISCH_LAST) begin
                    state_d = S_OFF;
                end
            end
            S_FAULT: begin
                if (fault_clr && (cnt_q == DISCH_LAST) && !cmd_on) begin
                    state_d = S_OFF;
                end
            end
            default: begin
                state_d      = S_FAULT;
                fault_code_d = 2'd3;
            end
        endcase

        if (state_d != S_FAULT) begin
            fault_code_d = 2'd0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            unique case (state_q)
                S_RAMP, S_DISCH: cnt_d = cnt_q + 1'b1;
                S_FAULT: cnt_d = (cnt_q == DISCH_LAST) ? cnt_q : cnt_q + 1'b1;
                default: cnt_d = '0;
            endcase
        end

        // Outputs are registered against the next state so they change on the
        // same edge that changes state.
        vn_on_d    = (state_d == S_RAMP) || (state_d == S_ON);
        hv_ready_d = (state_d == S_ON);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            vn_on_q      <= 1'b0;
            vn_pol_q     <= 1'b0;
            hv_ready_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vn_on_q      <= vn_on_d;
            vn_pol_q     <= vn_pol_d;
            hv_ready_q   <= hv_ready_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign vn_on      = vn_on_q;
    assign vn_pol     = vn_pol_q;
    assign hv_ready   = hv_ready_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_hv_sequencer.sv
// Directed bench for hv_sequencer: a vector table for the basic flow plus
// hand-written multi-cycle sequences for ramp, discharge, fault and reset.
module tb_hv_sequencer;

    localparam int RC = 20;
    localparam int DC = 10;

    localparam logic [2:0] OFF   = 3'd0;
    localparam logic [2:0] RAMP  = 3'd1;
    localparam logic [2:0] ON    = 3'd2;
    localparam logic [2:0] DISCH = 3'd3;
    localparam logic [2:0] FLT   = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_on = 1'b0;
    logic       cmd_pol = 1'b0;
    logic       fault_clr = 1'b0;
    logic       vn_l = 1'b1;
    logic       vn_h = 1'b0;
    logic       vn_on, vn_pol, hv_ready, fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hv_sequencer #(
        .RAMP_CYC (RC),
        .DISCH_CYC(DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_on    (cmd_on),
        .cmd_pol   (cmd_pol),
        .fault_clr (fault_clr),
        .vn_l      (vn_l),
        .vn_h      (vn_h),
        .vn_on     (vn_on),
        .vn_pol    (vn_pol),
        .hv_ready  (hv_ready),
        .fault     (fault),
        .fault_code(fault_code),
        .state     (state)
    );

    typedef struct packed {
        logic       on_i;
        logic       pol_i;
        logic       clr_i;
        logic       l_i;
        logic       h_i;
        logic [2:0] st;
        logic       on;
        logic       pol;
        logic       rdy;
        logic       flt;
        logic [1:0] code;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [2:0] st, input logic on,
                       input logic pol, input logic rdy, input logic flt,
                       input logic [1:0] code);
        logic [8:0] act;
        logic [8:0] exp;
        act = {state, vn_on, vn_pol, hv_ready, fault, fault_code};
        exp = {st, on, pol, rdy, flt, code};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d on=%b pol=%b rdy=%b flt=%b code=%0d, want st=%0d on=%b pol=%b rdy=%b flt=%b code=%0d",
                     nm, state, vn_on, vn_pol, hv_ready, fault, fault_code,
                     st, on, pol, rdy, flt, code);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic on, input logic pol, input logic clr,
                         input logic l, input logic h);
        cmd_on    = on;
        cmd_pol   = pol;
        fault_clr = clr;
        vn_l      = l;
        vn_h      = h;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OFF,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, OFF,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OFF,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, OFF,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RAMP, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RAMP, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RAMP, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ON,   1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ON,   1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, FLT,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FLT,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FLT,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1};

        #1 reset = 1'b1;
        #1 chk("reset_async", OFF, 0, 0, 0, 0, 2'd0);
        step();
        step();
        chk("reset_held", OFF, 0, 0, 0, 0, 2'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].on_i, tbl[i].pol_i, tbl[i].clr_i, tbl[i].l_i, tbl[i].h_i);
            step();
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].on, tbl[i].pol,
                tbl[i].rdy, tbl[i].flt, tbl[i].code);
        end

        // Fault clear rejected before saturation and while cmd_on is high.
        drive(0, 1, 1, 0, 0);
        step();
        chk("clr_early", FLT, 0, 1, 0, 1, 2'd1);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < DC; i++) step();
        chk("flt_sat", FLT, 0, 1, 0, 1, 2'd1);
        drive(1, 1, 1, 0, 0);
        step();
        chk("clr_cmd_on", FLT, 0, 1, 0, 1, 2'd1);
        drive(0, 1, 1, 0, 0);
        step();
        chk("clr_exit", OFF, 0, 1, 0, 0, 2'd0);

        // Normal on: polarity first, vn_l falls in the final RAMP cycle.
        drive(0, 0, 0, 1, 0);
        step();
        chk("off_pol0", OFF, 0, 0, 0, 0, 2'd0);
        drive(1, 1, 0, 1, 0);
        step();
        chk("pol_first", OFF, 0, 1, 0, 0, 2'd0);
        step();
        chk("ramp_entry", RAMP, 1, 1, 0, 0, 2'd0);
        for (int i = 0; i < RC - 1; i++) begin
            step();
            chk("ramp_hold", RAMP, 1, 1, 0, 0, 2'd0);
        end
        vn_l = 1'b0;
        step();
        chk("ramp_last_on", ON, 1, 1, 1, 0, 2'd0);

        // Polarity flip in ON, comparator noise ignored while discharging.
        cmd_pol = 1'b0;
        step();
        chk("flip_disch", DISCH, 0, 1, 0, 0, 2'd0);
        for (int i = 1; i < DC; i++) begin
            vn_h = i[0];
            vn_l = ~i[0];
            step();
            chk("disch_noise", DISCH, 0, 1, 0, 0, 2'd0);
        end
        vn_h = 1'b0;
        vn_l = 1'b1;
        step();
        chk("disch_off", OFF, 0, 1, 0, 0, 2'd0);
        step();
        chk("off_load_pol", OFF, 0, 0, 0, 0, 2'd0);
        step();
        chk("reramp", RAMP, 1, 0, 0, 0, 2'd0);

        // Early cmd_on drop, reassert while discharging.
        cmd_on = 1'b0;
        step();
        chk("early_drop", DISCH, 0, 0, 0, 0, 2'd0);
        cmd_on = 1'b1;
        for (int i = 1; i < DC; i++) begin
            step();
            chk("disch_reassert", DISCH, 0, 0, 0, 0, 2'd0);
        end
        step();
        chk("reassert_off", OFF, 0, 0, 0, 0, 2'd0);
        step();
        chk("reassert_ramp", RAMP, 1, 0, 0, 0, 2'd0);

        // Ramp timeout with vn_l stuck high.
        for (int i = 0; i < RC - 1; i++) step();
        chk("timeout_pre", RAMP, 1, 0, 0, 0, 2'd0);
        step();
        chk("timeout_flt", FLT, 0, 0, 0, 1, 2'd3);
        for (int i = 0; i < DC; i++) step();
        fault_clr = 1'b1;
        step();
        chk("to_clr_cmd_on", FLT, 0, 0, 0, 1, 2'd3);
        cmd_on = 1'b0;
        step();
        chk("to_clr_exit", OFF, 0, 0, 0, 0, 2'd0);

        // Undervoltage in ON, then asynchronous reset.
        drive(1, 0, 0, 1, 0);
        step();
        chk("uv_ramp", RAMP, 1, 0, 0, 0, 2'd0);
        vn_l = 1'b0;
        step();
        chk("uv_on", ON, 1, 0, 1, 0, 2'd0);
        vn_l = 1'b1;
        step();
        chk("uv_flt", FLT, 0, 0, 0, 1, 2'd2);
        #2 reset = 1'b1;
        #1 chk("rst_in_flt", OFF, 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ramp", RAMP, 1, 0, 0, 0, 2'd0);
        vn_l = 1'b0;
        step();
        chk("rst_on", ON, 1, 0, 1, 0, 2'd0);
        #2 reset = 1'b1;
        #1 chk("rst_in_on", OFF, 0, 0, 0, 0, 2'd0);
        cmd_on = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        chk("rst_idle", OFF, 0, 0, 0, 0, 2'd0);
        cmd_on = 1'b1;
        step();
        chk("rst_no_wait", RAMP, 1, 0, 0, 0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
